scanline_fill_buffer: RTL and testbench

Double-buffered scanline store that replaces the single-bit raster line buffer with a parametrised, multi-bit colour version. The edge stepper writes colour-tagged edge marks into the draw bank. The VGA scan side reads the display bank, accumulates marks into filled spans (or outlines only), and clears each pixel as it is shown. The banks swap on every `line_step`.

---
 rtl/toygpu_pkg.sv | 19 +
 rtl/scanline_fill_buffer_if.sv | 26 ++
 rtl/line_bank_ram.sv | 26 ++
 rtl/scanline_fill_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_scanline_fill_buffer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/toygpu_pkg.sv
// Shared constants and enums for the toy GPU raster blocks.
package toygpu_pkg;

  localparam int XW         = 10;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int COLOR_BITS = 3;

  typedef enum logic {
    FILL_PARITY  = 1'b0,
    FILL_OUTLINE = 1'b1
  } fill_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fill_state_e;

endpackage

// File: rtl/scanline_fill_buffer_if.sv
// Edge-mark handshake plus raster scan bus of the scanline fill buffer.
interface scanline_fill_buffer_if #(
  parameter int XW         = toygpu_pkg::XW,
  parameter int COLOR_BITS = toygpu_pkg::COLOR_BITS
);
  logic                  line_step;
  logic                  edge_valid;
  logic                  edge_ready;
  logic [XW-1:0]         edge_x;
  logic [COLOR_BITS-1:0] edge_color;
  logic [XW-1:0]         raster_x;
  logic [XW-1:0]         raster_y;
  logic [COLOR_BITS-1:0] pixel_color;

  // Producer side: edge stepper and VGA timing generator.
  modport master (
    output line_step, edge_valid, edge_x, edge_color, raster_x, raster_y,
    input  edge_ready, pixel_color
  );

  // Buffer side.
  modport slave (
    input  line_step, edge_valid, edge_x, edge_color, raster_x, raster_y,
    output edge_ready, pixel_color
  );
endinterface

// File: rtl/line_bank_ram.sv
// One scanline bank: simple dual-port RAM, one read and one write port,
// registered read (read-first on a same-address collision).
module line_bank_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 3,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port, no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/scanline_fill_buffer.sv
// Double-buffered colour scanline store: edge marks are XORed into the draw
// bank, the display bank is scanned into filled spans and cleared as shown.
module scanline_fill_buffer #(
  parameter int WIDTH      = toygpu_pkg::DEF_WIDTH,
  parameter int HEIGHT     = toygpu_pkg::DEF_HEIGHT,
  parameter int XW         = toygpu_pkg::XW,
  parameter int COLOR_BITS = toygpu_pkg::COLOR_BITS,
  parameter int FILL_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scanline_fill_buffer_if.slave bus
);
  import toygpu_pkg::*;

  localparam logic [XW:0]           WIDTH_X  = (XW+1)'(WIDTH);
  localparam logic [XW:0]           HEIGHT_X = (XW+1)'(HEIGHT);
  localparam logic [XW-1:0]         LAST_X   = XW'(WIDTH - 1);
  localparam logic [COLOR_BITS-1:0] ZERO_C   = '0;

  fill_state_e           state_q, state_d;
  logic [XW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  sel_q, sel_d;
  logic                  run_first_q, run_first_d;
  logic [XW-1:0]         prev_x_q, prev_x_d;

  // Draw read-modify-write second stage.
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_bank_q, s2_bank_d;
  logic [XW-1:0]         s2_x_q, s2_x_d;
  logic [COLOR_BITS-1:0] s2_color_q, s2_color_d;
  logic                  s2_fwd_q, s2_fwd_d;
  logic [COLOR_BITS-1:0] s2_fwd_data_q, s2_fwd_data_d;

  // Display second stage (read data returns, clear issued).
  logic                  d1_valid_q, d1_valid_d;
  logic                  d1_hit_q, d1_hit_d;
  logic                  d1_zero_q, d1_zero_d;
  logic                  d1_bank_q, d1_bank_d;
  logic [XW-1:0]         d1_x_q, d1_x_d;
  logic [COLOR_BITS-1:0] acc_q, acc_d;
  logic [COLOR_BITS-1:0] pixel_q, pixel_d;
  logic [COLOR_BITS-1:0] acc_base;

  logic                  run, edge_ready, accept, draw_hit;
  logic                  disp_evt, disp_hit, disp_bank;
  logic [COLOR_BITS-1:0] s2_wdata, disp_rd;

  logic                  bank_re    [2];
  logic                  bank_we    [2];
  logic [XW-1:0]         bank_raddr [2];
  logic [XW-1:0]         bank_waddr [2];
  logic [COLOR_BITS-1:0] bank_wdata [2];
  logic [COLOR_BITS-1:0] bank_rdata [2];

  // Handshake, pixel-event detection and the two stage-2 data values.
  always_comb begin
    run        = (state_q == ST_RUN);
    edge_ready = rst_n && run && !bus.line_step;
    accept     = bus.edge_valid && edge_ready;
    draw_hit   = accept && ({1'b0, bus.edge_x} < WIDTH_X);
    disp_evt   = run && ((bus.raster_x != prev_x_q) || run_first_q);
    disp_hit   = disp_evt && ({1'b0, bus.raster_x} < WIDTH_X)
                          && ({1'b0, bus.raster_y} < HEIGHT_X);
    disp_bank  = ~sel_q;
    // A same-address op one cycle ahead has not reached the RAM output yet,
    // so its result is carried along instead of the stale read.
    s2_wdata   = (s2_fwd_q ? s2_fwd_data_q : bank_rdata[s2_bank_q]) ^ s2_color_q;
    disp_rd    = bank_rdata[d1_bank_q];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic draw_rd, draw_wr, clr_wr;
      assign draw_rd = draw_hit && (sel_q == 1'(gi));
      assign draw_wr = s2_valid_q && (s2_bank_q == 1'(gi));
      assign clr_wr  = d1_hit_q && (d1_bank_q == 1'(gi));

      assign bank_re[gi]    = draw_rd || (disp_hit && (disp_bank == 1'(gi)));
      assign bank_raddr[gi] = draw_rd ? bus.edge_x : bus.raster_x;
      // Reset blocks every write so in-flight ops die with it; a draw write
      // takes the port over a clear-on-show to the same bank.
      assign bank_we[gi]    = rst_n && (!run || draw_wr || clr_wr);
      assign bank_waddr[gi] = !run ? clr_cnt_q : (draw_wr ? s2_x_q : d1_x_q);
      assign bank_wdata[gi] = (run && draw_wr) ? s2_wdata : ZERO_C;

      line_bank_ram #(
        .DEPTH (WIDTH),
        .DW    (COLOR_BITS),
        .AW    (XW)
      ) u_ram (
        .clk   (clk),
        .re    (bank_re[gi]),
        .raddr (bank_raddr[gi]),
        .rdata (bank_rdata[gi]),
        .we    (bank_we[gi]),
        .waddr (bank_waddr[gi]),
        .wdata (bank_wdata[gi])
      );
    end
  endgenerate

  // Next state: clear sweep, bank select, draw pipeline and span accumulator.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    sel_d         = sel_q;
    run_first_d   = 1'b0;
    prev_x_d      = bus.raster_x;
    s2_valid_d    = draw_hit;
    s2_bank_d     = sel_q;
    s2_x_d        = bus.edge_x;
    s2_color_d    = bus.edge_color;
    s2_fwd_d      = s2_valid_q && (s2_bank_q == sel_q) && (s2_x_q == bus.edge_x);
    s2_fwd_data_d = s2_wdata;
    d1_valid_d    = disp_evt;
    d1_hit_d      = disp_hit;
    d1_zero_d     = (bus.raster_x == '0);
    d1_bank_d     = disp_bank;
    d1_x_d        = bus.raster_x;
    acc_d         = acc_q;
    pixel_d       = pixel_q;
    acc_base      = d1_zero_q ? ZERO_C : acc_q;

    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        acc_d     = '0;
        pixel_d   = '0;
        if (clr_cnt_q == LAST_X) begin
          state_d     = ST_RUN;
          clr_cnt_d   = '0;
          run_first_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.line_step) sel_d = ~sel_q;
        if (d1_valid_q) begin
          if (d1_hit_q) begin
            acc_d   = acc_base ^ disp_rd;
            pixel_d = (FILL_MODE == int'(FILL_OUTLINE)) ? disp_rd : (acc_base ^ disp_rd);
          end else begin
            acc_d   = acc_base;
            pixel_d = '0;
          end
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      sel_q         <= 1'b0;
      run_first_q   <= 1'b0;
      prev_x_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_bank_q     <= 1'b0;
      s2_x_q        <= '0;
      s2_color_q    <= '0;
      s2_fwd_q      <= 1'b0;
      s2_fwd_data_q <= '0;
      d1_valid_q    <= 1'b0;
      d1_hit_q      <= 1'b0;
      d1_zero_q     <= 1'b0;
      d1_bank_q     <= 1'b0;
      d1_x_q        <= '0;
      acc_q         <= '0;
      pixel_q       <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      sel_q         <= sel_d;
      run_first_q   <= run_first_d;
      prev_x_q      <= prev_x_d;
      s2_valid_q    <= s2_valid_d;
      s2_bank_q     <= s2_bank_d;
      s2_x_q        <= s2_x_d;
      s2_color_q    <= s2_color_d;
      s2_fwd_q      <= s2_fwd_d;
      s2_fwd_data_q <= s2_fwd_data_d;
      d1_valid_q    <= d1_valid_d;
      d1_hit_q      <= d1_hit_d;
      d1_zero_q     <= d1_zero_d;
      d1_bank_q     <= d1_bank_d;
      d1_x_q        <= d1_x_d;
      acc_q         <= acc_d;
      pixel_q       <= pixel_d;
    end
  end

  assign bus.edge_ready  = edge_ready;
  assign bus.pixel_color = pixel_q;
endmodule

// File: tb/tb_scanline_fill_buffer.sv
// Self-checking bench: a parity-fill and an outline instance share one
// stimulus stream and are compared against a line-buffer model.
module tb_scanline_fill_buffer;
  localparam int W = 640;
  localparam int H = 480;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_step, edge_valid;
  logic [9:0] edge_x, raster_x, raster_y;
  logic [2:0] edge_color;

  always #5 clk = ~clk;

  scanline_fill_buffer_if #(.XW(10), .COLOR_BITS(3)) bus_p ();
  scanline_fill_buffer_if #(.XW(10), .COLOR_BITS(3)) bus_o ();

  assign bus_p.line_step  = line_step;
  assign bus_p.edge_valid = edge_valid;
  assign bus_p.edge_x     = edge_x;
  assign bus_p.edge_color = edge_color;
  assign bus_p.raster_x   = raster_x;
  assign bus_p.raster_y   = raster_y;
  assign bus_o.line_step  = line_step;
  assign bus_o.edge_valid = edge_valid;
  assign bus_o.edge_x     = edge_x;
  assign bus_o.edge_color = edge_color;
  assign bus_o.raster_x   = raster_x;
  assign bus_o.raster_y   = raster_y;

  scanline_fill_buffer #(.WIDTH(W), .HEIGHT(H), .XW(10), .COLOR_BITS(3), .FILL_MODE(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .bus(bus_p.slave));
  scanline_fill_buffer #(.WIDTH(W), .HEIGHT(H), .XW(10), .COLOR_BITS(3), .FILL_MODE(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bus(bus_o.slave));

  int vectors = 0;
  int miscompares = 0;

  // Model: two line stores; marks XOR into the draw line, a scan shows and
  // empties the display line, line_step exchanges them.
  logic [2:0] mdl_bank [2][W];
  int         mdl_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int x = 0; x < W; x++) begin
      mdl_bank[0][x] = 3'd0;
      mdl_bank[1][x] = 3'd0;
    end
    mdl_sel = 0;
  endtask

  task automatic drive_cycle(input bit v, input int x, input int c, input bit step, input string tag);
    edge_valid = v;
    edge_x     = 10'(x);
    edge_color = 3'(c);
    line_step  = step;
    #1;
    vectors++;
    if (bus_p.edge_ready !== !step || bus_o.edge_ready !== !step) begin
      miscompares++;
      $display("FAIL %s edge_ready: got %b/%b want %b", tag, bus_p.edge_ready, bus_o.edge_ready, !step);
    end
    if (v && !step && x < W) mdl_bank[mdl_sel][x] ^= 3'(c);
    if (step) mdl_sel ^= 1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 0, 0, 1'b0, "idle");
  endtask

  task automatic step_line();
    idle(1);
    drive_cycle(1'b0, 0, 0, 1'b1, "step");
    idle(1);
  endtask

  task automatic scan_line(input int y, input string tag);
    logic [2:0] exp_p [W];
    logic [2:0] exp_o [W];
    logic [2:0] run_acc;
    int db;
    db = 1 - mdl_sel;
    run_acc = 3'd0;
    for (int x = 0; x < W; x++) begin
      exp_o[x] = (y < H) ? mdl_bank[db][x] : 3'd0;
      run_acc ^= exp_o[x];
      exp_p[x] = run_acc;
      if (y < H) mdl_bank[db][x] = 3'd0;
    end
    edge_valid = 1'b0;
    line_step  = 1'b0;
    raster_y   = 10'(y);
    for (int i = 0; i < W + 2; i++) begin
      if (i >= 2) begin
        vectors += 2;
        if (bus_p.pixel_color !== exp_p[i-2]) begin
          miscompares++;
          $display("FAIL %s parity y=%0d x=%0d: got %0d want %0d", tag, y, i-2, bus_p.pixel_color, exp_p[i-2]);
        end
        if (bus_o.pixel_color !== exp_o[i-2]) begin
          miscompares++;
          $display("FAIL %s outline y=%0d x=%0d: got %0d want %0d", tag, y, i-2, bus_o.pixel_color, exp_o[i-2]);
        end
      end
      raster_x = (i < W) ? 10'(i) : 10'd1023;
      tick();
    end
    $display("scan %s y=%0d done", tag, y);
  endtask

  task automatic wait_clear(input string tag);
    int n_p, n_o;
    bit done;
    n_p = 0;
    n_o = 0;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      #1;
      if (bus_p.edge_ready !== 1'b1) n_p++;
      if (bus_o.edge_ready !== 1'b1) n_o++;
      if (bus_p.edge_ready === 1'b1 && bus_o.edge_ready === 1'b1) done = 1'b1;
      else tick();
    end
    vectors++;
    if (!done || n_p != W || n_o != W) begin
      miscompares++;
      $display("FAIL %s clear_len: got %0d/%0d cycles (ready=%b) want %0d", tag, n_p, n_o, done, W);
    end
    $display("%s: ready after %0d/%0d clear cycles", tag, n_p, n_o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_step = 1'b0; edge_valid = 1'b0; edge_x = '0; edge_color = '0;
    raster_x = 10'd1023; raster_y = '0;
    repeat (3) tick();
    #1;
    vectors += 2;
    if (bus_p.edge_ready !== 1'b0 || bus_o.edge_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ready: got %b/%b want 0", bus_p.edge_ready, bus_o.edge_ready);
    end
    if (bus_p.pixel_color !== 3'd0 || bus_o.pixel_color !== 3'd0) begin
      miscompares++;
      $display("FAIL reset pixel: got %0d/%0d want 0", bus_p.pixel_color, bus_o.pixel_color);
    end
    rst_n = 1'b1;
    wait_clear("reset");
    model_reset();
    scan_line(0, "reset_scan");
  endtask

  task automatic test_parity_fill();
    drive_cycle(1'b1, 100, 5, 1'b0, "pf_mark");
    drive_cycle(1'b1, 200, 5, 1'b0, "pf_mark");
    step_line();
    scan_line(10, "parity");
    scan_line(11, "parity_cleared");
  endtask

  task automatic test_forwarding();
    drive_cycle(1'b1, 50, 3, 1'b0, "fwd_mark");
    drive_cycle(1'b1, 50, 6, 1'b0, "fwd_mark");
    step_line();
    scan_line(20, "forward");
  endtask

  task automatic test_outline();
    drive_cycle(1'b1, 10, 7, 1'b0, "ol_mark");
    drive_cycle(1'b1, 20, 2, 1'b0, "ol_mark");
    step_line();
    scan_line(30, "outline");
  endtask

  task automatic test_boundary();
    drive_cycle(1'b1, 640, 1, 1'b0, "x640_mark");
    drive_cycle(1'b1, 639, 1, 1'b0, "x639_mark");
    step_line();
    scan_line(480, "y_oob");
    scan_line(5, "x_edge");
  endtask

  task automatic test_swap_race();
    for (int k = 0; k < 5; k++)
      drive_cycle(1'b1, $urandom_range(0, W-1), $urandom_range(0, 7), 1'b0, "race_pre");
    drive_cycle(1'b1, $urandom_range(0, W-1), $urandom_range(0, 7), 1'b1, "race_swap");
    for (int k = 0; k < 5; k++)
      drive_cycle(1'b1, $urandom_range(0, W-1), $urandom_range(0, 7), 1'b0, "race_post");
    idle(2);
    scan_line(40, "race_old");
    step_line();
    scan_line(41, "race_new");
  endtask

  task automatic test_back_to_back();
    int last_x, x, n;
    last_x = 0;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) x = $urandom_range(W, 1023);
        else if ($urandom_range(0, 2) == 0) x = last_x;
        else x = $urandom_range(0, W-1);
        drive_cycle($urandom_range(0, 3) != 0, x, $urandom_range(0, 7), 1'b0, "rnd_mark");
        last_x = x;
      end
      step_line();
      if ($urandom_range(0, 3) != 0)
        scan_line(($urandom_range(0, 3) == 0) ? $urandom_range(H, 600) : $urandom_range(0, H-1), "random");
    end
    step_line();
    scan_line(100, "random_final");
  endtask

  task automatic test_reset_midrun();
    drive_cycle(1'b1, 100, 5, 1'b0, "mr_mark");
    drive_cycle(1'b1, 300, 5, 1'b0, "mr_mark");
    step_line();
    raster_y = 10'd50;
    raster_x = 10'd100;
    tick();
    tick();
    vectors++;
    if (bus_o.pixel_color !== mdl_bank[1-mdl_sel][100]) begin
      miscompares++;
      $display("FAIL midrun outline x=100: got %0d want %0d", bus_o.pixel_color, mdl_bank[1-mdl_sel][100]);
    end
    rst_n = 1'b0;
    raster_x = 10'd1023;
    tick();
    #1;
    vectors++;
    if (bus_p.edge_ready !== 1'b0 || bus_o.edge_ready !== 1'b0 ||
        bus_p.pixel_color !== 3'd0 || bus_o.pixel_color !== 3'd0) begin
      miscompares++;
      $display("FAIL midrun reset outputs: ready %b/%b pixel %0d/%0d want 0", bus_p.edge_ready,
               bus_o.edge_ready, bus_p.pixel_color, bus_o.pixel_color);
    end
    rst_n = 1'b1;
    wait_clear("midrun");
    model_reset();
    scan_line(7, "post_reset");
    step_line();
    scan_line(8, "post_reset_other");
  endtask

  initial begin
    test_reset();
    test_parity_fill();
    test_forwarding();
    test_outline();
    test_boundary();
    test_swap_race();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
